// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// wb_src_e names the requester slots used by the scheduler's valid/ready vectors.
package rf_pkg;

   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int NUM_REGS   = 32;
   localparam int NUM_WB_SRC = 3;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_LSU = 2'd1,
      WB_MDU = 2'd2
   } wb_src_e;

   // Round-robin successor of idx among n slots.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or above ptr.
// ptr moves to just past the winner whenever advance_i is strobed.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int N = NUM_WB_SRC
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] valid_i,
   input  logic         advance_i,
   output logic [N-1:0] grant_o
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gidx;
   logic          found;
   int            idx;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment; a path that leaves one unassigned infers a latch.
   always_comb begin
      grant_o = '0;
      gidx    = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr_q) + i) % N;
         if (!found && valid_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            gidx         = PW'(idx);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = PW'(rr_next(int'(gidx), N));
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // their inputs from the same pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates ALU/LSU/MDU writebacks onto the single regfile write port through a
// one-cycle output stage, and tracks outstanding destinations for RAW stalls.
module rf_wb_scheduler
   import rf_pkg::*;
#(
   parameter int NUM_REQ = NUM_WB_SRC,
   parameter int XLEN    = rf_pkg::XLEN,
   parameter int REG_AW  = rf_pkg::REG_AW
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ*REG_AW-1:0] i_req_addr,
   input  logic [NUM_REQ*XLEN-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   output logic [REG_AW-1:0]         o_rd_addr,
   output logic [XLEN-1:0]           o_rd_data,
   output logic                      o_rd_wren,
   input  logic                      i_iss_valid,
   input  logic [REG_AW-1:0]         i_iss_rd,
   input  logic [REG_AW-1:0]         i_rs1_addr,
   input  logic [REG_AW-1:0]         i_rs2_addr,
   output logic                      o_rs1_busy,
   output logic                      o_rs2_busy,
   output logic [2**REG_AW-1:0]      o_pending
);

   localparam int NREGS = 2**REG_AW;

   logic [NUM_REQ-1:0] grant;
   logic               any_grant;
   logic [REG_AW-1:0]  sel_addr;
   logic [XLEN-1:0]    sel_data;

   logic [REG_AW-1:0]  rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]    rd_data_q, rd_data_d;
   logic               rd_wren_q, rd_wren_d;
   logic [NREGS-1:1]   pending_q, pending_d;

   assign any_grant = |grant;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk_i     (i_clk),
      .rst_ni    (i_reset),
      .valid_i   (i_req_valid),
      .advance_i (any_grant),
      .grant_o   (grant)
   );

   // Reset is asynchronous, so ready must also drop without waiting for ptr to clear.
   assign o_req_ready = grant & {NUM_REQ{i_reset}};

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_addr = i_req_addr[k*REG_AW +: REG_AW];
            sel_data = i_req_data[k*XLEN +: XLEN];
         end
      end
   end

   // Writes to x0 are accepted and captured but never raise wren.
   always_comb begin
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      rd_wren_d = 1'b0;
      if (any_grant) begin
         rd_addr_d = sel_addr;
         rd_data_d = sel_data;
         rd_wren_d = (sel_addr != '0);
      end
   end

   // Clear first, then set, so a new producer issued on the retiring edge stays tracked.
   always_comb begin
      pending_d = pending_q;
      if (rd_wren_q) begin
         pending_d[rd_addr_q] = 1'b0;
      end
      if (i_iss_valid && (i_iss_rd != '0)) begin
         pending_d[i_iss_rd] = 1'b1;
      end
   end

   // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared by reset
   // along with the control state; the output data register is reset too so the
   // regfile port never presents X.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rd_addr_q <= '0;
         rd_data_q <= '0;
         rd_wren_q <= 1'b0;
         pending_q <= '0;
      end else begin
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         rd_wren_q <= rd_wren_d;
         pending_q <= pending_d;
      end
   end

   assign o_rd_addr  = rd_addr_q;
   assign o_rd_data  = rd_data_q;
   assign o_rd_wren  = rd_wren_q;
   assign o_pending  = {pending_q, 1'b0};
   assign o_rs1_busy = o_pending[i_rs1_addr];
   assign o_rs2_busy = o_pending[i_rs2_addr];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed scenarios followed by randomized traffic checked against a queue-free
// reference model of round-robin grant, one-cycle writeback and the pending set.
module tb_rf_wb_scheduler;
   import rf_pkg::*;

   localparam int NR = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic             i_clk;
   logic             i_reset;
   logic [NR-1:0]    i_req_valid;
   logic [NR*AW-1:0] i_req_addr;
   logic [NR*DW-1:0] i_req_data;
   logic [NR-1:0]    o_req_ready;
   logic [AW-1:0]    o_rd_addr;
   logic [DW-1:0]    o_rd_data;
   logic             o_rd_wren;
   logic             i_iss_valid;
   logic [AW-1:0]    i_iss_rd;
   logic [AW-1:0]    i_rs1_addr;
   logic [AW-1:0]    i_rs2_addr;
   logic             o_rs1_busy;
   logic             o_rs2_busy;
   logic [31:0]      o_pending;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   rf_wb_scheduler #(.NUM_REQ(NR), .XLEN(DW), .REG_AW(AW)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_req_valid (i_req_valid),
      .i_req_addr  (i_req_addr),
      .i_req_data  (i_req_data),
      .o_req_ready (o_req_ready),
      .o_rd_addr   (o_rd_addr),
      .o_rd_data   (o_rd_data),
      .o_rd_wren   (o_rd_wren),
      .i_iss_valid (i_iss_valid),
      .i_iss_rd    (i_iss_rd),
      .i_rs1_addr  (i_rs1_addr),
      .i_rs2_addr  (i_rs2_addr),
      .o_rs1_busy  (o_rs1_busy),
      .o_rs2_busy  (o_rs2_busy),
      .o_pending   (o_pending)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      i_req_valid[k]        = v;
      i_req_addr[k*AW +: AW] = a;
      i_req_data[k*DW +: DW] = d;
   endtask

   // Reference model state
   int          m_ptr;
   logic [31:0] m_pend;
   logic        m_wren;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        r_act  [NR];
   logic [4:0]  r_addr [NR];
   logic [31:0] r_data [NR];

   initial begin
      int          eg;
      logic [31:0] npend;
      logic        iss_v;
      logic [4:0]  iss_rd;

      i_reset     = 1'b0;
      i_req_valid = '0;
      i_req_addr  = '0;
      i_req_data  = '0;
      i_iss_valid = 1'b0;
      i_iss_rd    = '0;
      i_rs1_addr  = '0;
      i_rs2_addr  = '0;

      // Reset held with every requester valid
      for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(k + 1), 32'h1000_0000 + k);
      tick();
      tick();
      check("rst_ready", 64'(o_req_ready), 64'(3'b000));
      check("rst_wren", 64'(o_rd_wren), 64'd0);
      check("rst_pending", 64'(o_pending), 64'd0);
      check("rst_addr", 64'(o_rd_addr), 64'd0);
      check("rst_data", 64'(o_rd_data), 64'd0);
      i_reset = 1'b1;
      #1;
      check("first_grant", 64'(o_req_ready), 64'(3'b001));

      // Fairness: all three continuously valid
      for (int c = 0; c < 6; c++) begin
         check("fair_ready", 64'(o_req_ready), 64'(3'b001 << (c % 3)));
         tick();
         check("fair_wren", 64'(o_rd_wren), 64'd1);
         check("fair_addr", 64'(o_rd_addr), 64'((c % 3) + 1));
         check("fair_data", 64'(o_rd_data), 64'(32'h1000_0000 + (c % 3)));
      end
      i_req_valid = '0;
      tick();
      check("idle_wren", 64'(o_rd_wren), 64'd0);

      // Single request from the LSU slot
      set_req(int'(WB_LSU), 1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      check("single_ready", 64'(o_req_ready), 64'(3'b010));
      tick();
      i_req_valid = '0;
      check("single_wren", 64'(o_rd_wren), 64'd1);
      check("single_addr", 64'(o_rd_addr), 64'd5);
      check("single_data", 64'(o_rd_data), 64'hDEAD_BEEF);
      tick();
      check("single_wren_off", 64'(o_rd_wren), 64'd0);
      check("single_addr_hold", 64'(o_rd_addr), 64'd5);
      check("single_data_hold", 64'(o_rd_data), 64'hDEAD_BEEF);

      // Write to x0 from the MDU slot
      set_req(int'(WB_MDU), 1'b1, 5'd0, 32'h0000_1234);
      #1;
      check("x0_ready", 64'(o_req_ready), 64'(3'b100));
      tick();
      check("x0_wren", 64'(o_rd_wren), 64'd0);
      check("x0_pending", 64'(o_pending), 64'd0);
      i_req_valid = 3'b111;
      #1;
      check("x0_ptr_adv", 64'(o_req_ready), 64'(3'b001));
      i_req_valid = '0;

      // Scoreboard: issue x7, then LSU retires it
      i_iss_valid = 1'b1;
      i_iss_rd    = 5'd7;
      i_rs1_addr  = 5'd7;
      #1;
      check("sb_busy_before", 64'(o_rs1_busy), 64'd0);
      tick();
      i_iss_valid = 1'b0;
      check("sb_busy_m1", 64'(o_rs1_busy), 64'd1);
      check("sb_pending", 64'(o_pending), 64'h80);
      set_req(int'(WB_LSU), 1'b1, 5'd7, 32'hA5A5_0007);
      #1;
      check("sb_lsu_ready", 64'(o_req_ready), 64'(3'b010));
      tick();
      i_req_valid = '0;
      check("sb_wren", 64'(o_rd_wren), 64'd1);
      check("sb_busy_n1", 64'(o_rs1_busy), 64'd1);
      tick();
      check("sb_busy_n2", 64'(o_rs1_busy), 64'd0);
      check("sb_pending_clr", 64'(o_pending), 64'd0);

      // Re-issue of x7 on the same edge that retires it
      i_iss_valid = 1'b1;
      i_iss_rd    = 5'd7;
      tick();
      i_iss_valid = 1'b0;
      set_req(int'(WB_LSU), 1'b1, 5'd7, 32'h0000_0077);
      tick();
      i_req_valid = '0;
      check("coll_wren", 64'(o_rd_wren), 64'd1);
      i_iss_valid = 1'b1;
      i_iss_rd    = 5'd7;
      tick();
      i_iss_valid = 1'b0;
      i_rs1_addr  = 5'd0;
      i_rs2_addr  = 5'd7;
      #1;
      check("coll_pending", 64'(o_pending), 64'h80);
      check("coll_rs2_busy", 64'(o_rs2_busy), 64'd1);
      check("rs_x0_busy", 64'(o_rs1_busy), 64'd0);

      // Asynchronous reset while a write is in the output stage
      set_req(int'(WB_ALU), 1'b1, 5'd3, 32'h0BAD_F00D);
      tick();
      check("ar_wren_pre", 64'(o_rd_wren), 64'd1);
      check("ar_pending_pre", 64'(o_pending), 64'h80);
      i_reset = 1'b0;
      #1;
      check("ar_wren", 64'(o_rd_wren), 64'd0);
      check("ar_pending", 64'(o_pending), 64'd0);
      check("ar_addr", 64'(o_rd_addr), 64'd0);
      check("ar_data", 64'(o_rd_data), 64'd0);
      check("ar_ready", 64'(o_req_ready), 64'd0);
      i_req_valid = '0;
      #1;
      i_reset = 1'b1;

      // Randomized traffic against the reference model
      m_ptr  = 0;
      m_pend = '0;
      m_wren = 1'b0;
      m_addr = '0;
      m_data = '0;
      for (int k = 0; k < NR; k++) begin
         r_act[k]  = 1'b0;
         r_addr[k] = '0;
         r_data[k] = '0;
      end

      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int k = 0; k < NR; k++) begin
            if (!r_act[k] && ($urandom % 2 == 0)) begin
               r_act[k]  = 1'b1;
               r_addr[k] = 5'($urandom % 32);
               r_data[k] = $urandom;
            end
            set_req(k, r_act[k], r_addr[k], r_data[k]);
         end
         iss_v       = ($urandom % 3 == 0);
         iss_rd      = 5'($urandom % 32);
         i_iss_valid = iss_v;
         i_iss_rd    = iss_rd;
         i_rs1_addr  = 5'($urandom % 32);
         i_rs2_addr  = 5'($urandom % 32);
         #1;

         eg = -1;
         for (int i = 0; i < NR; i++) begin
            if (eg < 0 && r_act[(m_ptr + i) % NR]) eg = (m_ptr + i) % NR;
         end
         check("rnd_ready", 64'(o_req_ready), (eg < 0) ? 64'd0 : 64'(1) << eg);
         check("rnd_pending", 64'(o_pending), 64'(m_pend));
         check("rnd_rs1_busy", 64'(o_rs1_busy), 64'(m_pend[i_rs1_addr]));
         check("rnd_rs2_busy", 64'(o_rs2_busy), 64'(m_pend[i_rs2_addr]));

         tick();
         npend = m_pend;
         if (m_wren) npend[m_addr] = 1'b0;
         if (iss_v && iss_rd != 5'd0) npend[iss_rd] = 1'b1;
         m_pend = npend;
         if (eg >= 0) begin
            m_addr    = r_addr[eg];
            m_data    = r_data[eg];
            m_wren    = (r_addr[eg] != 5'd0);
            m_ptr     = (eg + 1) % NR;
            r_act[eg] = 1'b0;
         end else begin
            m_wren = 1'b0;
         end
         check("rnd_wren", 64'(o_rd_wren), 64'(m_wren));
         check("rnd_addr", 64'(o_rd_addr), 64'(m_addr));
         check("rnd_data", 64'(o_rd_data), 64'(m_data));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
